// File: rtl/mdu_unit_pkg.sv
// Shared constants and types for the multiply/divide unit: md_op codes, the
// writeback source code of the MDU result, FSM encodings and the datapath result type.
package mdu_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam logic [2:0] REGW_SRC_MDU = 3'd4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
  } mdu_calc_res_t;

  // Only these opcodes may launch a multi-cycle operation.
  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: produces the 64-bit {hi,lo} result
// for mult/multu/div/divu plus a divide-by-zero flag.
module mdu_calc
  import mdu_unit_pkg::*;
(
  input  logic [3:0]    op_i,
  input  logic [31:0]   a_i,
  input  logic [31:0]   b_i,
  output mdu_calc_res_t res_o
);

  logic signed [63:0] a_sext;
  logic signed [63:0] b_sext;
  logic        [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] num;
  logic        [31:0] den;
  logic        [31:0] quo;
  logic        [31:0] rem;
  logic               is_signed_div;

  always_comb begin
    a_sext = {{32{a_i[31]}}, a_i};
    b_sext = {{32{b_i[31]}}, b_i};
    prod_s = a_sext * b_sext;
    prod_u = {32'd0, a_i} * {32'd0, b_i};
  end

  // One shared unsigned divider; signed division runs on magnitudes and the
  // signs are restored afterwards. 0x80000000 / -1 falls out as 0x80000000, rem 0.
  always_comb begin
    is_signed_div = (op_i == MD_DIV);
    num = (is_signed_div && a_i[31]) ? (32'd0 - a_i) : a_i;
    den = (is_signed_div && b_i[31]) ? (32'd0 - b_i) : b_i;
    if (den == 32'd0) begin
      den = 32'd1;
    end
    quo = num / den;
    rem = num % den;
    if (is_signed_div) begin
      if (a_i[31] ^ b_i[31]) begin
        quo = 32'd0 - quo;
      end
      if (a_i[31]) begin
        rem = 32'd0 - rem;
      end
    end
  end

  always_comb begin
    res_o = '0;
    case (op_i)
      MD_MULT: begin
        res_o.hi = prod_s[63:32];
        res_o.lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_o.hi = prod_u[63:32];
        res_o.lo = prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_o.hi          = rem;
        res_o.lo          = quo;
        res_o.div_by_zero = (b_i == 32'd0);
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// busy period, handles mthi/mtlo and serves mfhi/mflo through mdu_res.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mdu_res
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [0:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   temp_hi_q, temp_hi_d;
  logic [31:0]   temp_lo_q, temp_lo_d;
  logic          dz_q, dz_d;
  logic          accept;
  mdu_calc_res_t calc_res;

  mdu_calc u_calc (
    .op_i  (md_op),
    .a_i   (rs_val),
    .b_i   (rt_val),
    .res_o (calc_res)
  );

  assign accept = (state_q == ST_IDLE) && start && is_start_op(md_op);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    dz_d      = dz_q;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        temp_hi_d = calc_res.hi;
        temp_lo_d = calc_res.lo;
        dz_d      = calc_res.div_by_zero;
        cnt_d     = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
        state_d   = ST_RUN;
      end else if (!start) begin
        if (md_op == MD_MTHI) hi_d = rs_val;
        if (md_op == MD_MTLO) lo_d = rs_val;
      end
    end else begin
      // A zero divisor still burns the full busy period but leaves HI/LO alone.
      if (cnt_q == 4'd1) begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        if (!dz_q) begin
          hi_d = temp_hi_q;
          lo_d = temp_lo_q;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      dz_q      <= dz_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

  always_comb begin
    case (md_op)
      MD_MFHI: mdu_res = hi_q;
      MD_MFLO: mdu_res = lo_q;
      default: mdu_res = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed-vector bench for mdu_unit: hand-computed HI/LO results, busy
// durations, ignored illegal requests and asynchronous reset mid-operation.
module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] mdu_res;

  int checks = 0;
  int errors = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .start   (start),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .mdu_res (mdu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Present one operation for exactly one rising edge; returns at the
  // falling edge after that edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st);
    @(negedge clk);
    md_op  = op;
    rs_val = a;
    rt_val = b;
    start  = st;
    @(negedge clk);
    start  = 1'b0;
    md_op  = 4'd0;
  endtask

  // Counts falling edges at which busy is seen high, starting with the current one.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    reset  = 1'b0;
    md_op  = 4'd0;
    start  = 1'b0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // mult: -1 * 2 = -2
    do_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    wait_idle(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFFE);
    md_op = 4'd7; #1;
    chk("mfhi", mdu_res, 32'hFFFF_FFFF);
    md_op = 4'd8; #1;
    chk("mflo", mdu_res, 32'hFFFF_FFFE);
    md_op = 4'd0; #1;
    chk("mdu_res_none", mdu_res, 32'd0);

    // multu: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    do_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    wait_idle(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", hi_out, 32'h0000_0001);
    chk("multu_lo", lo_out, 32'hFFFF_FFFE);

    // div: -7 / 2 = -3 rem -1
    do_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    wait_idle(n);
    chk("div_cycles", n, 32'd10);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);
    chk("div_lo", lo_out, 32'hFFFF_FFFD);

    // div overflow corner: INT_MIN / -1
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle(n);
    chk("div_ovf_hi", hi_out, 32'h0000_0000);
    chk("div_ovf_lo", lo_out, 32'h8000_0000);

    // divu: 0x80000000 / 0xFFFFFFFF = 0 rem 0x80000000
    do_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle(n);
    chk("divu_cycles", n, 32'd10);
    chk("divu_hi", hi_out, 32'h8000_0000);
    chk("divu_lo", lo_out, 32'h0000_0000);

    // mthi 0, mtlo 0x1234, then divu by zero leaves both untouched
    do_op(4'd5, 32'h0000_0000, 32'd0, 1'b0);
    chk("mthi_hi", hi_out, 32'h0000_0000);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    do_op(4'd6, 32'h0000_1234, 32'd0, 1'b0);
    chk("mtlo_lo", lo_out, 32'h0000_1234);
    chk("mtlo_hi_keep", hi_out, 32'h0000_0000);
    do_op(4'd4, 32'h0000_0055, 32'h0000_0000, 1'b1);
    chk("dz_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("dz_cycles", n, 32'd10);
    chk("dz_lo", lo_out, 32'h0000_1234);
    chk("dz_hi", hi_out, 32'h0000_0000);

    // div 100 / 7 = 14 rem 2, with a mult start and an mthi issued mid-flight
    do_op(4'd3, 32'd100, 32'd7, 1'b1);
    @(negedge clk);
    md_op = 4'd1; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = 4'd5; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    md_op = 4'd7; #1;
    chk("mfhi_busy_old", mdu_res, 32'h0000_0000);
    md_op = 4'd0;
    chk("ign_hi_mid", hi_out, 32'h0000_0000);
    wait_idle(n);
    chk("ign_cycles", n + 3, 32'd10);
    chk("ign_hi", hi_out, 32'h0000_0002);
    chk("ign_lo", lo_out, 32'h0000_000E);
    @(negedge clk);
    chk("ign_busy_after", {31'd0, busy}, 32'd0);

    // Asynchronous reset during busy cycle 4 of a div
    do_op(4'd3, 32'd20, 32'd3, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_hi", hi_out, 32'd0);
    chk("async_lo", lo_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("late_busy", {31'd0, busy}, 32'd0);
    chk("late_hi", hi_out, 32'd0);
    chk("late_lo", lo_out, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
